// File: rtl/rlc_decoder.sv
// Run/level word stream decoder: expands 16-bit RLC pairs back into a dense frame of LENGTH elements.
// Optional macro RLC_DECODER_STATS_EN adds NZ_COUNT, the nonzero-element count of the last frame.
module rlc_decoder #(
   parameter int unsigned LENGTH = 1594,
   parameter int unsigned CNT_W  = 11,
   parameter int unsigned RUN_W  = 5
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [15:0]       IN_DATA,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic [15:0]       OUT_DATA,
   output logic              OUT_VALID,
   output logic              OUT_LAST,
   output logic              DONE,
`ifdef RLC_DECODER_STATS_EN
   output logic [CNT_W-1:0]  NZ_COUNT,
`endif
   output logic              ERR
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned VAL_W  = 15;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_LEVEL = 3'd1,
      S_ZERO  = 3'd2,
      S_EMIT  = 3'd3,
      S_PAD   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [RUN_W-1:0]   run, run_d;
   logic [VAL_W-1:0]   value, value_d;
   logic               last, last_d;

   logic [DATA_W-1:0]  out_data_c;
   logic               out_valid_c;
   logic               out_last_c;
   logic               done_c;
   logic               err_c;
   logic               at_end_c;

   // Where a pair goes once its zero run (if any) is exhausted.
   function automatic state_t tail_state(input logic [VAL_W-1:0] v, input logic l);
      state_t s;
      if (v != '0)
         s = S_EMIT;
      else if (l)
         s = S_PAD;
      else
         s = S_RUN;
      return s;
   endfunction

   assign IN_READY = (state == S_RUN) || (state == S_LEVEL);

   always_ff @(posedge CLK) begin
      if (!RESET)
         state <= S_RUN;
      else
         state <= state_d;
   end

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      run_d       = run;
      value_d     = value;
      last_d      = last;
      out_data_c  = '0;
      out_valid_c = 1'b0;
      out_last_c  = 1'b0;
      done_c      = 1'b0;
      err_c       = 1'b0;
      at_end_c    = (cnt == LAST_IDX);

      case (state)
         S_RUN: begin
            if (IN_VALID) begin
               run_d   = IN_DATA[RUN_W-1:0];
               err_c   = |IN_DATA[DATA_W-1:RUN_W];
               state_d = S_LEVEL;
            end
         end
         S_LEVEL: begin
            if (IN_VALID) begin
               value_d = IN_DATA[VAL_W-1:0];
               last_d  = IN_DATA[DATA_W-1];
               if (run != '0)
                  state_d = S_ZERO;
               else
                  state_d = tail_state(IN_DATA[VAL_W-1:0], IN_DATA[DATA_W-1]);
            end
         end
         S_ZERO: begin
            out_valid_c = 1'b1;
            run_d       = run - RUN_W'(1);
            // Frame full with zeros or a level still owed: drop the rest of the pair.
            if (at_end_c) begin
               state_d = S_DONE;
               err_c   = (run != RUN_W'(1)) || (value != '0);
            end else if (run == RUN_W'(1)) begin
               state_d = tail_state(value, last);
            end
         end
         S_EMIT: begin
            out_valid_c = 1'b1;
            out_data_c  = {1'b0, value};
            if (at_end_c)
               state_d = S_DONE;
            else if (last)
               state_d = S_PAD;
            else
               state_d = S_RUN;
         end
         S_PAD: begin
            out_valid_c = 1'b1;
            if (at_end_c)
               state_d = S_DONE;
         end
         S_DONE: begin
            done_c  = 1'b1;
            cnt_d   = '0;
            state_d = S_RUN;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      if (out_valid_c) begin
         out_last_c = at_end_c;
         cnt_d      = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         cnt       <= '0;
         run       <= '0;
         value     <= '0;
         last      <= 1'b0;
         OUT_DATA  <= '0;
         OUT_VALID <= 1'b0;
         OUT_LAST  <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         cnt       <= cnt_d;
         run       <= run_d;
         value     <= value_d;
         last      <= last_d;
         OUT_DATA  <= out_data_c;
         OUT_VALID <= out_valid_c;
         OUT_LAST  <= out_last_c;
         DONE      <= done_c;
         ERR       <= ERR | err_c;
      end
   end

`ifdef RLC_DECODER_STATS_EN
   logic [CNT_W-1:0] nz_frame;

   // Every S_EMIT cycle carries a nonzero value; publish the total alongside DONE.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         nz_frame <= '0;
         NZ_COUNT <= '0;
      end else if (state == S_DONE) begin
         NZ_COUNT <= nz_frame;
         nz_frame <= '0;
      end else if (state == S_EMIT) begin
         nz_frame <= nz_frame + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_rlc_decoder.sv
// Directed bench for rlc_decoder: a full-size instance plus an LENGTH=8 instance for overflow cases.
module tb_rlc_decoder;

   localparam int LEN = 1594;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        sel;

   logic        rdy_a, val_a, last_a, done_a, err_a;
   logic [15:0] data_a;
   logic        rdy_b, val_b, last_b, done_b, err_b;
   logic [15:0] data_b;
`ifdef RLC_DECODER_STATS_EN
   logic [10:0] nz_a;
   logic [3:0]  nz_b;
`endif

   logic        rdy, o_valid, o_last, o_done, o_err;
   logic [15:0] o_data;

   int checks;
   int errors;

   logic [15:0] outq[$];
   logic [15:0] expq[$];
   logic [15:0] words[$];
   int          lastq[$];
   int          done_cnt;
   int          rdy_out_cnt;

   always #5 clk = ~clk;

   rlc_decoder dut_a (
      .CLK(clk), .RESET(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid & ~sel),
      .IN_READY(rdy_a), .OUT_DATA(data_a), .OUT_VALID(val_a), .OUT_LAST(last_a),
      .DONE(done_a),
`ifdef RLC_DECODER_STATS_EN
      .NZ_COUNT(nz_a),
`endif
      .ERR(err_a)
   );

   rlc_decoder #(.LENGTH(8), .CNT_W(4), .RUN_W(5)) dut_b (
      .CLK(clk), .RESET(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid & sel),
      .IN_READY(rdy_b), .OUT_DATA(data_b), .OUT_VALID(val_b), .OUT_LAST(last_b),
      .DONE(done_b),
`ifdef RLC_DECODER_STATS_EN
      .NZ_COUNT(nz_b),
`endif
      .ERR(err_b)
   );

   assign rdy     = sel ? rdy_b  : rdy_a;
   assign o_valid = sel ? val_b  : val_a;
   assign o_last  = sel ? last_b : last_a;
   assign o_done  = sel ? done_b : done_a;
   assign o_err   = sel ? err_b  : err_a;
   assign o_data  = sel ? data_b : data_a;

   // Output capture on the falling edge.
   always @(negedge clk) begin
      if (o_valid) begin
         if (o_last) lastq.push_back(outq.size());
         outq.push_back(o_data);
         if (rdy) rdy_out_cnt++;
      end
      if (o_done) done_cnt++;
   end

   function automatic int first_diff();
      int n;
      n = (outq.size() < expq.size()) ? outq.size() : expq.size();
      for (int i = 0; i < n; i++)
         if (outq[i] !== expq[i]) return i;
      return -1;
   endfunction

   task automatic clr_mon();
      outq.delete();
      lastq.delete();
      expq.delete();
      done_cnt    = 0;
      rdy_out_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clr_mon();
   endtask

   task automatic send(input logic [15:0] d, input int gap);
      int b;
      repeat (gap) @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      b = 0;
      while (rdy !== 1'b1 && b < 4000) begin
         @(negedge clk);
         b++;
      end
      if (b >= 4000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: word %h not accepted after %0d cycles", d, b);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      int b;
      b = 0;
      while (done_cnt < n && b < budget) begin
         @(negedge clk);
         b++;
      end
      if (b >= budget) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got %0d DONE pulses, want %0d", done_cnt, n);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic fill_exp(input int zeros, input logic [15:0] v);
      repeat (zeros) expq.push_back(16'h0000);
      expq.push_back(v);
   endtask

   task automatic check_frame(input string name, input int nlen, input logic want_err);
      int d, lp;
      d  = first_diff();
      lp = (lastq.size() == 1) ? lastq[0] : -1;
      checks++;
      if (outq.size() !== nlen) begin
         errors++;
         $display("FAIL %s_count: got %0d elements, want %0d", name, outq.size(), nlen);
      end
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL %s_data: index %0d got %h want %h", name, d, outq[d], expq[d]);
      end
      checks++;
      if (lp !== nlen - 1) begin
         errors++;
         $display("FAIL %s_last: got OUT_LAST index %0d (%0d pulses), want %0d", name, lp, lastq.size(), nlen - 1);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s_done: got %0d DONE pulses, want 1", name, done_cnt);
      end
      checks++;
      if (o_err !== want_err) begin
         errors++;
         $display("FAIL %s_err: got ERR=%b want %b", name, o_err, want_err);
      end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      checks++;
      if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_err); end
      checks++;
      if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy); end
      checks++;
      if (o_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", o_data); end
   endtask

   task automatic test_stream();
      sel = 1'b0;
      do_reset();
      send(16'd2, 0); send(16'd5, 0);
      send(16'd0, 0); send(16'd7, 0);
      send(16'd0, 0); send(16'h8009, 0);
      wait_done(1, 4000);
      fill_exp(2, 16'd5);
      fill_exp(0, 16'd7);
      fill_exp(0, 16'd9);
      repeat (LEN - 5) expq.push_back(16'h0000);
      check_frame("stream", LEN, 1'b0);
   endtask

   task automatic test_escape();
      sel = 1'b0;
      do_reset();
      send(16'd31, 0); send(16'h0000, 0);
      send(16'd31, 0); send(16'h0000, 0);
      send(16'd3, 0);  send(16'h8001, 0);
      wait_done(1, 4000);
      fill_exp(65, 16'd1);
      repeat (LEN - 66) expq.push_back(16'h0000);
      check_frame("escape", LEN, 1'b0);
      // Only the S_RUN cycle straight after each escape expansion overlaps a visible output.
      checks++;
      if (rdy_out_cnt !== 2) begin
         errors++;
         $display("FAIL escape_ready: got %0d ready cycles during output, want 2", rdy_out_cnt);
      end
   endtask

   task automatic test_overflow();
      int d;
      sel = 1'b1;
      do_reset();
      send(16'd10, 0); send(16'd4, 0);
      send(16'd0, 0);  send(16'h8000, 0);
      wait_done(2, 500);
      repeat (16) expq.push_back(16'h0000);
      d = first_diff();
      checks++;
      if (outq.size() !== 16) begin errors++; $display("FAIL ovf_count: got %0d want 16", outq.size()); end
      checks++;
      if (d !== -1) begin errors++; $display("FAIL ovf_data: index %0d got %h want 0000", d, outq[d]); end
      checks++;
      if (lastq.size() !== 2) begin
         errors++;
         $display("FAIL ovf_last_count: got %0d OUT_LAST pulses want 2", lastq.size());
      end else begin
         checks++;
         if (lastq[0] !== 7 || lastq[1] !== 15) begin
            errors++;
            $display("FAIL ovf_last_pos: got %0d,%0d want 7,15", lastq[0], lastq[1]);
         end
      end
      checks++;
      if (done_cnt !== 2) begin errors++; $display("FAIL ovf_done: got %0d want 2", done_cnt); end
      checks++;
      if (o_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", o_err); end
      sel = 1'b0;
   endtask

   task automatic test_random_map();
      logic [15:0] fmap[LEN];
      int run;
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < LEN; i++) begin
         if (i < 3 || (i >= 600 && i < 700))
            fmap[i] = 16'h0000;
         else if (i == 3 || i == LEN - 1 || $urandom_range(0, 3) == 0)
            fmap[i] = 16'($urandom_range(1, 32767));
         else
            fmap[i] = 16'h0000;
      end
      words.delete();
      run = 0;
      for (int i = 0; i < LEN; i++) begin
         if (fmap[i] == 16'h0000) begin
            if (run == 31) begin
               words.push_back(16'd31);
               words.push_back(16'h0000);
               run = 0;
            end
            run++;
         end else begin
            words.push_back(16'(run));
            words.push_back((i == LEN - 1) ? (16'h8000 | fmap[i]) : fmap[i]);
            run = 0;
         end
      end
      // First run word carries stray high bits; run field 3 must still apply.
      words[0] = words[0] | 16'h0020;
      foreach (words[k]) send(words[k], $urandom_range(0, 3));
      wait_done(1, 8000);
      for (int i = 0; i < LEN; i++) expq.push_back(fmap[i]);
      check_frame("random", LEN, 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      int b;
      sel = 1'b0;
      do_reset();
      send(16'd0, 0); send(16'h8001, 0);
      b = 0;
      while (outq.size() < 100 && b < 1000) begin
         @(negedge clk);
         b++;
      end
      checks++;
      if (outq.size() < 100) begin
         errors++;
         $display("FAIL midrst_progress: got %0d elements, want at least 100", outq.size());
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clr_mon();
      repeat (20) @(negedge clk);
      checks++;
      if (outq.size() !== 0 || done_cnt !== 0) begin
         errors++;
         $display("FAIL midrst_quiet: got %0d elements %0d DONE after reset, want 0 0", outq.size(), done_cnt);
      end
      send(16'd0, 0); send(16'h8002, 0);
      wait_done(1, 4000);
      fill_exp(0, 16'd2);
      repeat (LEN - 1) expq.push_back(16'h0000);
      check_frame("midrst", LEN, 1'b0);
`ifdef RLC_DECODER_STATS_EN
      checks++;
      if (nz_a !== 11'd1) begin errors++; $display("FAIL midrst_nz: got %0d want 1", nz_a); end
`endif
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      sel      = 1'b0;
      clr_mon();
      test_reset();
      test_stream();
      test_escape();
      test_overflow();
      test_random_map();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rlc_decoder.md
Name: rlc_decoder

Overview:
- Receives the 16-bit run/level word stream produced by the depthwise-separable convolution RLC encoder.
- Expands it back into the dense ReLU'd pointwise feature map of LENGTH elements, one element per cycle.
- Sits after the encoder in the bench and downstream datapath; used for loopback checking and feature-map reconstruction.

Parameters:
- LENGTH, 1594, number of elements per reconstructed frame.
- CNT_W, 11, width of the element counter; must satisfy 2**CNT_W >= LENGTH.
- RUN_W, 5, width of the run field; the maximum run is 31.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- IN_DATA  input  16  RLC word (run or level).
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  decoder accepts a word this cycle.
- OUT_DATA  output  16  reconstructed element.
- OUT_VALID  output  1  OUT_DATA valid.
- OUT_LAST  output  1  high with element LENGTH-1.
- DONE  output  1  one-cycle pulse after the last element.
- ERR  output  1  sticky protocol error flag.

Behaviour:
- Reset (RESET=0 at a clock edge):
  - State goes to S_RUN; counters clear.
  - OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, DONE=0, ERR=0.
  - Reset applied mid-frame abandons the frame; no partial output follows.
- Handshake:
  - A word transfers on an edge where IN_VALID=1 and IN_READY=1.
  - IN_READY=1 only in S_RUN and S_LEVEL.
  - No output backpressure: OUT_VALID is never stalled.
- Word format:
  - Words alternate strictly: run, then level.
  - Run word: run = IN_DATA[4:0]. IN_DATA[15:5] != 0 sets ERR; the low field is still used.
  - Level word: IN_DATA[15] = LAST flag; IN_DATA[14:0] = value.
- Pair meaning:
  - value != 0: emit run zeros, then value.
  - value == 0, LAST=0: escape; emit run zeros only (long zero runs as chained 31s).
  - LAST=1: after the pair, pad zeros until LENGTH elements are out.
- States:
  - S_RUN: accept run word, latch it, go to S_LEVEL.
  - S_LEVEL: accept level word, latch value and LAST.
    - Next state S_ZERO if run>0; else S_EMIT if value!=0; else S_PAD if LAST; else S_RUN.
  - S_ZERO: emit OUT_DATA=0 per cycle, decrementing run. When the last zero is emitted, go to S_EMIT / S_PAD / S_RUN by the same rule.
  - S_EMIT: emit OUT_DATA={1'b0,value} for one cycle, then S_PAD if LAST, else S_RUN.
  - S_PAD: emit zeros until element LENGTH-1.
  - S_DONE: DONE=1 for one cycle, element counter cleared, then S_RUN for the next frame.
- Timing:
  - Output is registered: level word accepted at edge t gives the first element at edge t+1.
  - A pair (N, value!=0) takes N+1 output cycles.
  - Minimum gap between a level acceptance and the next run acceptance is the expansion length.
- Element counter:
  - Increments on every OUT_VALID.
  - OUT_LAST=1 exactly when counter == LENGTH-1, from any state. The next state is then S_DONE.
- Overflow:
  - If LENGTH is reached with zeros or a level still pending, ERR=1 and the remainder of that pair is discarded.
  - Further input is not accepted until S_DONE completes.
  - Pairs after the overflow belong to the next frame.
- Underflow: LAST arriving early is not an error; S_PAD fills the frame.
- A level with value != 0 arriving at element index LENGTH-1 is emitted with OUT_LAST=1.
- ERR clears only on reset.

Optional Feature:
- Macro: RLC_DECODER_STATS_EN.
- Defined:
  - Adds output NZ_COUNT[CNT_W-1:0]: the number of nonzero elements emitted in the frame.
  - Updated on the DONE cycle and held until the next DONE.
  - Resets to 0.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset: hold RESET=0 for 2 cycles, then release -> OUT_VALID=0, ERR=0, DONE=0, IN_READY=1 on the first cycle after release.
2. Stream (2,5),(0,7),(0,0x8009) -> outputs 0,0,5,7,9, then 1589 zeros. OUT_LAST on output 1594, DONE pulse on the next cycle, ERR=0.
3. Escape: (31,0),(31,0),(3,0x8001) -> 65 zeros, then 1, then 1528 zeros. Total 1594; IN_READY=0 throughout each 31-cycle expansion.
4. Overflow with LENGTH=8: send (10,4),(0,0x8000) -> 8 zeros with OUT_LAST on the 8th, ERR=1, DONE pulse. The second pair then starts a new frame of 8 zeros.
5. Handshake: IN_VALID toggling with random gaps, and a run word with IN_DATA=0x0023 -> run=3 is decoded correctly and ERR=1. No word is dropped or duplicated versus the golden encoder output of a random feature map.
6. Reset mid-frame after 100 elements, then a fresh stream (0,0x8002) -> first output is 2 at index 0, 1593 zeros follow, DONE pulses once. With RLC_DECODER_STATS_EN, NZ_COUNT=1.
